// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// over WIDTH cycles, with a one-cycle fast path for divide-by-zero and signed overflow.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       rd,
    output logic             busy,
    output logic             done,
    output logic             we,
    output logic [4:0]       wa,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONES    = '1;
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             we_q, we_d;
    logic [4:0]       wa_q, wa_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [2:0]       op_q, op_d;
    logic [4:0]       rd_q, rd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic             neg_q, neg_d;
    logic             nega_q, nega_d;

    logic             in_sa, in_sb, a_neg, b_neg, in_div;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, div_rs, div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] final_res;

    // Operand decode at acceptance: signedness per op, magnitudes and result signs
    always_comb begin
        in_div = funct3[2];
        in_sa  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        in_sb  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg  = in_sa & a[WIDTH-1];
        b_neg  = in_sb & b[WIDTH-1];
        mag_a  = neg_w(a, a_neg);
        mag_b  = neg_w(b, b_neg);
    end

    // One iteration step of each algorithm; hi stays below the divisor so WIDTH+1 bits suffice
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bmag_q} : {(WIDTH+1){1'b0}});
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
        div_rs   = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_rs - {1'b0, bmag_q};
        div_ok   = ~div_diff[WIDTH];
        div_hi_n = div_ok ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0];
        div_lo_n = {lo_q[WIDTH-2:0], div_ok};
        prod     = neg_2w({mul_hi_n, mul_lo_n}, neg_q);
        if (op_q[2]) begin
            final_res = op_q[1] ? neg_w(div_hi_n, nega_q) : neg_w(div_lo_n, neg_q);
        end else begin
            final_res = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        we_d     = we_q;
        wa_d     = wa_q;
        result_d = result_q;
        op_d     = op_q;
        rd_d     = rd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        bmag_d   = bmag_q;
        neg_d    = neg_q;
        nega_d   = nega_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = funct3;
                    rd_d   = rd;
                    bmag_d = mag_b;
                    neg_d  = a_neg ^ b_neg;
                    nega_d = a_neg;
                    hi_d   = '0;
                    lo_d   = mag_a;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (in_div && (b == '0)) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        we_d     = (rd != 5'd0);
                        wa_d     = rd;
                        result_d = funct3[1] ? a : ONES;
                    end else if (in_div && !funct3[0] && (a == INT_MIN) && (b == ONES)) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        we_d     = (rd != 5'd0);
                        wa_d     = rd;
                        result_d = funct3[1] ? '0 : INT_MIN;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                hi_d  = op_q[2] ? div_hi_n : mul_hi_n;
                lo_d  = op_q[2] ? div_lo_n : mul_lo_n;
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    we_d     = (rd_q != 5'd0);
                    wa_d     = rd_q;
                    result_d = final_res;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                we_d    = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        op_q   <= op_d;
        rd_q   <= rd_d;
        hi_q   <= hi_d;
        lo_q   <= lo_d;
        bmag_q <= bmag_d;
        neg_q  <= neg_d;
        nega_q <= nega_d;
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            wa_q     <= 5'd0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign we     = we_q;
    assign wa     = wa_q;
    assign result = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed ops push expected write-backs, a monitor
// pops and compares them whenever done pulses.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  rd = '0;
    logic        busy, done, we;
    logic [4:0]  wa;
    logic [31:0] result;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic prev_done = 1'b0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wa;
        logic        we;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .a(a), .b(b), .rd(rd),
        .busy(busy), .done(done), .we(we), .wa(wa), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (done && prev_done) begin
                bad++;
                $display("FAIL done_twice: done high in consecutive cycles at %0d", cyc);
            end
            if (we && !done) begin
                bad++;
                $display("FAIL we_without_done: we=1 done=0 at %0d", cyc);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: actual result=%h we=%b wa=%0d, required no done", result, we, wa);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("wa", {27'd0, wa}, {27'd0, e.wa});
                    chk("we", {31'd0, we}, {31'd0, e.we});
                    chk("done_cycle", cyc, e.cyc);
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy || done) begin
            bad++;
            $display("FAIL idle_timeout: busy=%b done=%b, required both 0", busy, done);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                          input logic [4:0] r, input logic [31:0] ex, input int lat);
        @(negedge clk);
        funct3 = f; a = av; b = bv; rd = r; start = 1'b1;
        sb.push_back('{ex, r, (r != 5'd0), cyc + lat});
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_wa", {27'd0, wa}, 32'd0);
        chk("rst_result", result, 32'd0);
        reset = 1'b0;

        // multiplies: full WIDTH+1 latency
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 33);
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFE, 33);
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'h00000000, 33);
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFF, 33);

        // iterative divides
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFD, 33);
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF, 33);
        run_op(3'b101, 32'd100, 32'd7, 5'd11, 32'd14, 33);
        run_op(3'b111, 32'd100, 32'd7, 5'd12, 32'd2, 33);
        run_op(3'b110, 32'd7, 32'hFFFFFFFE, 5'd13, 32'd1, 33);
        run_op(3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0, 33);

        // fast path
        run_op(3'b100, 32'd5, 32'd0, 5'd15, 32'hFFFFFFFF, 1);
        run_op(3'b110, 32'd5, 32'd0, 5'd16, 32'd5, 1);
        run_op(3'b101, 32'd5, 32'd0, 5'd17, 32'hFFFFFFFF, 1);
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1);
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0, 1);

        // rd=0 suppresses we; a start while busy is ignored
        @(negedge clk);
        funct3 = 3'b000; a = 32'd3; b = 32'd4; rd = 5'd0; start = 1'b1;
        sb.push_back('{32'd12, 5'd0, 1'b0, cyc + 33});
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        funct3 = 3'b101; a = 32'd5; b = 32'd0; rd = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignore_start", {31'd0, busy}, 32'd1);
        wait_idle();
        repeat (3) @(negedge clk);

        // reset mid-divide abandons the write-back
        @(negedge clk);
        funct3 = 3'b100; a = 32'd100; b = 32'd7; rd = 5'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_we", {31'd0, we}, 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
